// File: rtl/parallel_serializer.sv
// rtl/parallel_serializer.sv - parallel frame to serial word stream, val/rdy on both sides
// Words are shifted out LSB-first; the final word is not shifted away so send_msg holds it in IDLE.
module parallel_serializer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [N_SAMPLES*BIT_WIDTH-1:0] recv_msg,
    input  logic                           recv_val,
    output logic                           recv_rdy,
    output logic [BIT_WIDTH-1:0]           send_msg,
    output logic                           send_val,
    input  logic                           send_rdy
);

    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]                     r_state;
    logic [IDX_W-1:0]               r_idx;
    logic [N_SAMPLES*BIT_WIDTH-1:0] r_buf;

    logic w_is_last;
    logic w_recv_fire;
    logic w_send_fire;

    assign w_is_last   = (r_idx == LAST_IDX);
    assign send_val    = (r_state == S_SEND);
    assign send_msg    = r_buf[BIT_WIDTH-1:0];
    // Zero-bubble reload: accept the next frame in the cycle the last word leaves.
    assign recv_rdy    = !RESET && ((r_state == S_IDLE) || (send_rdy && w_is_last));
    assign w_recv_fire = recv_val && recv_rdy;
    assign w_send_fire = send_val && send_rdy;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_buf   <= '0;
        end else if (w_recv_fire) begin
            r_state <= S_SEND;
            r_idx   <= '0;
            r_buf   <= recv_msg;
        end else if (w_send_fire) begin
            if (w_is_last) begin
                r_state <= S_IDLE;
                r_idx   <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
                r_buf <= r_buf >> BIT_WIDTH;
            end
        end
    end

endmodule
